input_conditioner: RTL
======================

# input_conditioner

Multi-channel front end that sits directly upstream of `counter`. It turns raw asynchronous button/switch levels (inc, carry_in, carry_en, max_en) into clean levels and single-cycle rising-edge pulses. Each channel is synchronised, debounced and edge-detected independently, so `counter` only ever sees glitch-free, clock-aligned strobes. Optional auto-repeat gives a held `inc` button repeated count pulses.

## Interface
- `CHANNELS`, 4: number of independent input channels.
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronised cycles required to accept a change; must be ≥2.
- `REPEAT_DELAY`, 64: cycles from the initial pulse to the first repeat pulse; must be ≥ `REPEAT_RATE`.
- `REPEAT_RATE`, 16: cycles between subsequent repeat pulses; must be ≥2.
- `REPEAT_MASK`, `CHANNELS'b0001`: per-channel auto-repeat enable; bit 0 is the `inc` channel.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  one clock; reset is asynchronous and active-low (0 = reset).
- `raw_in`  input  `CHANNELS`  raw asynchronous inputs; active-high.
- `level_out`  output  `CHANNELS`  debounced level per channel.
- `pulse_out`  output  `CHANNELS`  one-cycle strobe per accepted press or repeat.

## Operation
- Reset (`reset`=0, asynchronous): synchroniser flops, debounce counters, repeat counters, `level_out` and `pulse_out` all go to 0 immediately. They hold at 0 until the first rising edge after release.
- Synchroniser: two flops per channel. `sync` is `raw_in` delayed by 2 edges.
- Debounce, per channel, with counter width `$clog2(DEBOUNCE_CYCLES)`:
  - If `sync` == `level_out`: counter ← 0.
  - If `sync` ≠ `level_out` and counter < `DEBOUNCE_CYCLES`-1: counter increments.
  - If `sync` ≠ `level_out` and counter == `DEBOUNCE_CYCLES`-1: `level_out` ← `sync` and counter ← 0.
  - A mismatch shorter than `DEBOUNCE_CYCLES` consecutive cycles is discarded, because the counter restarts from 0.
- Edge pulse: on the edge where `level_out` goes 0→1, `pulse_out` is registered 1 for exactly that cycle. The 1→0 transition produces no pulse.
- Channels are fully independent. Simultaneous changes on several channels produce simultaneous pulses.
- Reset mid-operation aborts any debounce or repeat in progress. If `raw_in` is still high after release, it is treated as a new press: after the full latency, `level_out` rises and one pulse is produced.
- Auto-repeat is described under Configuration.

## Timing
- Latency: `level_out` and `pulse_out` change on the (`DEBOUNCE_CYCLES`+2)th rising edge counted from the first edge that samples the new `raw_in` value. This holds for both press and release.
- `pulse_out` width is exactly 1 clock. Consecutive pulses on a channel are never adjacent.
- Outputs are driven directly from flops; there is no combinational path from `raw_in`.
- `pulse_out` aligns with the `counter` `inc` sampling: one pulse produces one count step.

## Configuration
- Macro: `INPUT_CONDITIONER_AUTOREPEAT_EN`.
- Defined: applies to each channel with its `REPEAT_MASK` bit set.
  - While `level_out` stays 1, a repeat counter runs from the initial pulse.
  - An extra `pulse_out` is issued `REPEAT_DELAY` cycles after the initial pulse, then every `REPEAT_RATE` cycles.
  - When `level_out` falls, the repeat counter clears on the same edge and no further pulses are issued.
  - Reset clears the repeat counter.
- Not defined: no repeat logic is compiled in. Exactly one pulse is produced per accepted press, and `REPEAT_*` parameters are ignored.

## Test plan
Bench parameters: `CHANNELS`=4, `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=8, `REPEAT_RATE`=3, `REPEAT_MASK`=4'b0001.

1. Reset asserted with `raw_in`=4'b1111 → all outputs 0 during reset. After release, `level_out`=4'b1111 and a single `pulse_out`=4'b1111 on the 6th edge.
2. `raw_in[1]` clean press held for 20 cycles → `level_out[1]` rises on the 6th edge with a 1-cycle `pulse_out[1]`. Release → `level_out[1]` falls 6 edges later with no pulse.
3. `raw_in[2]` glitches high for 3 cycles, low for 1, high for 3 → `level_out[2]` and `pulse_out[2]` stay 0.
4. `raw_in[0]` held for 30 cycles:
   - With the macro defined → pulses at edges 6, 14, 17, 20, 23, … while held.
   - Without the macro → a single pulse at edge 6.
5. `raw_in[3]` held for 20 cycles with the macro defined → only one pulse (mask bit clear).
6. Reset asserted mid-repeat on channel 0 → outputs clear asynchronously. `raw_in[0]` still high after release → a new pulse 6 edges after release.

Source files
------------

// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchroniser, debouncer and rising-edge
// pulse generator for raw button/switch levels feeding `counter`.
// Optional auto-repeat for masked channels: define INPUT_CONDITIONER_AUTOREPEAT_EN.
// Reset is asynchronous and active-low on port `reset`.
module input_conditioner #(
    parameter int                  CHANNELS        = 4,
    parameter int                  DEBOUNCE_CYCLES = 16,
    parameter int                  REPEAT_DELAY    = 64,
    parameter int                  REPEAT_RATE     = 16,
    parameter logic [CHANNELS-1:0] REPEAT_MASK     = CHANNELS'(1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] pulse_out
);

    localparam int             DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Reject parameter sets the debouncer/repeat timers cannot honour.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_RATE < 2 || REPEAT_DELAY < REPEAT_RATE ||
        $bits(REPEAT_MASK) != CHANNELS) begin : g_bad_params
        $error("input_conditioner: illegal parameter combination");
    end

    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] pulse_q, pulse_d;
    logic [DB_W-1:0]     db_cnt_q [CHANNELS];
    logic [DB_W-1:0]     db_cnt_d [CHANNELS];
    logic [CHANNELS-1:0] rise;

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        level_d = level_q;
        for (int c = 0; c < CHANNELS; c++) begin
            db_cnt_d[c] = '0;
            if (sync2_q[c] != level_q[c]) begin
                if (db_cnt_q[c] == DB_LAST) begin
                    level_d[c]  = sync2_q[c];
                    db_cnt_d[c] = '0;
                end else begin
                    db_cnt_d[c] = db_cnt_q[c] + 1'b1;
                end
            end
        end
        rise = level_d & ~level_q;
    end

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
    localparam int              RP_W        = $clog2(REPEAT_DELAY);
    localparam logic [RP_W-1:0] RP_DELAY_LD = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RP_RATE_LD  = RP_W'(REPEAT_RATE - 1);

    logic [RP_W-1:0]     rpt_cnt_q [CHANNELS];
    logic [RP_W-1:0]     rpt_cnt_d [CHANNELS];
    logic [CHANNELS-1:0] rpt_fire;

    // Repeat timer: down-counter loaded on the press pulse, fires at terminal count
    // and reloads with the repeat rate; cleared whenever the level is (going) low.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            rpt_cnt_d[c] = rpt_cnt_q[c];
            rpt_fire[c]  = 1'b0;
            if (!REPEAT_MASK[c] || !level_d[c]) begin
                rpt_cnt_d[c] = '0;
            end else if (rise[c]) begin
                rpt_cnt_d[c] = RP_DELAY_LD;
            end else if (rpt_cnt_q[c] == '0) begin
                rpt_fire[c]  = 1'b1;
                rpt_cnt_d[c] = RP_RATE_LD;
            end else begin
                rpt_cnt_d[c] = rpt_cnt_q[c] - 1'b1;
            end
        end
        pulse_d = rise | rpt_fire;
    end

    // Repeat timer state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < CHANNELS; c++) rpt_cnt_q[c] <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) rpt_cnt_q[c] <= rpt_cnt_d[c];
        end
    end
`else
    // Without auto-repeat only the accepted press produces a pulse.
    always_comb begin
        pulse_d = rise;
    end
`endif

    // Synchroniser, debounce counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            pulse_q <= '0;
            for (int c = 0; c < CHANNELS; c++) db_cnt_q[c] <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            for (int c = 0; c < CHANNELS; c++) db_cnt_q[c] <= db_cnt_d[c];
        end
    end

    assign level_out = level_q;
    assign pulse_out = pulse_q;

endmodule
